// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states,
// and the wait-counter width.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wide enough to count up to the largest legal WAIT_CYCLES (7).
    localparam int WAIT_W = 3;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dm_state_e;

endpackage

// File: rtl/dm_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data-memory
// controller (slave).
interface dm_ctrl_if;

    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, size, sext, addr, wdata, pc,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, we, size, sext, addr, wdata, pc,
        output ready, done, rdata, err
    );

endinterface

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane logic: store merge into the old word, load
// extraction with sign/zero extension, and alignment checking.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        sext,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [3:0]  mask,
    output logic [31:0] merged,
    output logic [31:0] load_val,
    output logic        misalign
);

    logic [31:0] shifted;
    logic [31:0] lanes;

    always_comb begin
        shifted  = old_word >> {lo, 3'b000};
        mask     = 4'b0000;
        lanes    = wdata;
        load_val = old_word;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                mask     = 4'b0001 << lo;
                lanes    = {4{wdata[7:0]}};
                load_val = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                mask     = lo[1] ? 4'b1100 : 4'b0011;
                lanes    = {2{wdata[15:0]}};
                load_val = {{16{sext & shifted[15]}}, shifted[15:0]};
                misalign = lo[0];
            end
            SZ_WORD: begin
                mask     = 4'b1111;
                misalign = (lo != 2'b00);
            end
            default: mask = 4'b0000;
        endcase
        // Replicated store data lets each lane pick its byte without a shifter.
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = mask[k] ? lanes[8*k +: 8] : old_word[8*k +: 8];
        end
    end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: clear sweep, req/done handshake with wait states,
// byte/half/word access with error reporting. Define DM_WRITE_LOG_EN to log stores.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072,
    parameter int WAIT_CYCLES = 1
) (
    input  logic     clk,
    input  logic     rst,
    dm_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0]  CLR_LAST  = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

    dm_state_e         state;
    logic [IDX_W-1:0]  clr_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ready_q, done_q, err_q;
    logic [31:0]       rdata_q;

    logic              lat_we, lat_sext;
    logic [1:0]        lat_size;
    logic [31:0]       lat_addr, lat_wdata, lat_pc;
    logic [31:0]       old_word;
    logic [31:0]       mem [DEPTH_WORDS];

    logic [3:0]        lane_mask;
    logic [31:0]       merged, load_val;
    logic              misalign, range_err, bad, commit, mem_wr, in_range;

    dm_lane_unit u_lane (
        .size     (lat_size),
        .lo       (lat_addr[1:0]),
        .sext     (lat_sext),
        .old_word (old_word),
        .wdata    (lat_wdata),
        .mask     (lane_mask),
        .merged   (merged),
        .load_val (load_val),
        .misalign (misalign)
    );

    assign in_range  = bus.addr[31:2] < 30'(DEPTH_WORDS);
    assign range_err = lat_addr[31:2] >= 30'(DEPTH_WORDS);
    assign bad       = (lat_size == 2'b11) | misalign | range_err;
    assign commit    = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);
    assign mem_wr    = !rst && commit && lat_we && !bad && (|lane_mask);

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

    // The word is read on the accept edge so the commit edge only merges and writes;
    // nothing else can write the array in between.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR)
                mem[clr_idx] <= '0;
            else if (mem_wr)
                mem[lat_addr[IDX_W+1:2]] <= merged;
            if (state == ST_IDLE && bus.req)
                old_word <= in_range ? mem[bus.addr[IDX_W+1:2]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_idx  <= '0;
            wait_cnt <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == CLR_LAST) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.req) begin
                        lat_we    <= bus.we;
                        lat_size  <= bus.size;
                        lat_sext  <= bus.sext;
                        lat_addr  <= bus.addr;
                        lat_wdata <= bus.wdata;
                        lat_pc    <= bus.pc;
                        wait_cnt  <= '0;
                        state     <= ST_WAIT;
                        ready_q   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (commit) begin
                        state   <= ST_RESP;
                        done_q  <= 1'b1;
                        err_q   <= bad;
                        rdata_q <= (bad || lat_we) ? 32'h0 : load_val;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (mem_wr)
            $display("%d@%h: *%h <= %h", $time, lat_pc, {lat_addr[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^lat_pc;
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: directed scenarios plus random traffic checked
// against a byte-addressed reference memory.
module tb_dm_ctrl;
    import dm_pkg::*;

    localparam int DEPTH = 3072;
    localparam int WAITC = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dm_ctrl_if bus();

    dm_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        bit          chk_rdata;
        int          due;
        string       name;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   op_no    = 0;
    exp_t sb[$];
    logic [7:0] bmem [0:DEPTH*4-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: memory as a flat little-endian byte array.
    function automatic void model(input bit we, input logic [1:0] size, input bit sext,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rd);
        int n;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((addr % n) != 0) || ((addr >> 2) >= DEPTH);
        rd  = '0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < n; i++) bmem[addr + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) rd[8*i +: 8] = bmem[addr + i];
            if (sext && n < 4 && rd[8*n-1])
                for (int i = n; i < 4; i++) rd[8*i +: 8] = 8'hFF;
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
                if (e.chk_rdata) check({e.name, "_rdata"}, bus.rdata, e.rdata);
                check({e.name, "_latency"}, cyc, e.due);
            end
        end
    end

    task automatic issue(input string name, input bit we, input logic [1:0] size, input bit sext,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit track);
        int          n;
        exp_t        e;
        logic        er;
        logic [31:0] rd;
        n = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_ready_timeout actual=ready_low required=ready_high", name);
            return;
        end
        bus.req   = 1'b1;
        bus.we    = we;
        bus.size  = size;
        bus.sext  = sext;
        bus.addr  = addr;
        bus.wdata = wdata;
        bus.pc    = 32'h0040_0000 + 32'(op_no * 4);
        op_no++;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        if (track) begin
            model(we, size, sext, addr, wdata, er, rd);
            e.err       = er;
            e.rdata     = rd;
            e.chk_rdata = !we;
            e.due       = cyc + 1 + WAITC;
            e.name      = name;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        int n;
        @(negedge clk);
        rst     = 1'b1;
        bus.req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < DEPTH*4; i++) bmem[i] = 8'h00;
        @(negedge clk);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_err",   {31'd0, bus.err},  32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        n = 0;
        while (bus.ready !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("clear_cycles", n, DEPTH);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          k, nb;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sext = 1'b0;
        bus.addr = '0; bus.wdata = '0; bus.pc = '0;
        repeat (2) @(negedge clk);

        do_reset();
        issue("lw_0", 0, SZ_WORD, 0, 32'h0, 32'h0, 1);

        issue("sw_10",    1, SZ_WORD, 0, 32'h10, 32'h1234_5678, 1);
        issue("lb_13",    0, SZ_BYTE, 1, 32'h13, 32'h0, 1);
        issue("lbu_10",   0, SZ_BYTE, 0, 32'h10, 32'h0, 1);
        issue("lh_12",    0, SZ_HALF, 1, 32'h12, 32'h0, 1);

        issue("sb_21",    1, SZ_BYTE, 0, 32'h21, 32'h0000_0080, 1);
        issue("lb_21",    0, SZ_BYTE, 1, 32'h21, 32'h0, 1);
        issue("lbu_21",   0, SZ_BYTE, 0, 32'h21, 32'h0, 1);
        issue("lw_20",    0, SZ_WORD, 0, 32'h20, 32'h0, 1);

        issue("sw_30",    1, SZ_WORD, 0, 32'h30, 32'hCAFE_F00D, 1);
        issue("err_lw22", 0, SZ_WORD, 0, 32'h22, 32'h0, 1);
        issue("err_sh31", 1, SZ_HALF, 0, 32'h31, 32'h0000_BEEF, 1);
        issue("err_lw3k", 0, SZ_WORD, 0, 32'h3000, 32'h0, 1);
        issue("err_sz3s", 1, 2'b11,   0, 32'h30, 32'hFFFF_FFFF, 1);
        issue("err_sz3l", 0, 2'b11,   1, 32'h30, 32'h0, 1);
        issue("lw_30",    0, SZ_WORD, 0, 32'h30, 32'h0, 1);
        issue("lw_20b",   0, SZ_WORD, 0, 32'h20, 32'h0, 1);

        // Second request held high while ready is low must be ignored.
        issue("hs_lw", 0, SZ_WORD, 0, 32'h10, 32'h0, 1);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = SZ_WORD; bus.addr = 32'h50;
        bus.wdata = 32'hAAAA_5555;
        repeat (3) @(posedge clk);
        #1;
        bus.req = 1'b0;
        drain();
        issue("hs_lw50", 0, SZ_WORD, 0, 32'h50, 32'h0, 1);
        drain();

        for (int i = 0; i < 300; i++) begin
            k  = $urandom_range(0, 15);
            sz = (k < 5) ? SZ_BYTE : (k < 10) ? SZ_HALF : (k < 15) ? SZ_WORD : 2'b11;
            nb = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
            k  = $urandom_range(0, 15);
            if (k == 0)      a = $urandom();
            else if (k == 1) a = 32'h3000 + $urandom_range(0, 255);
            else begin
                a = $urandom_range(0, 255);
                if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
            end
            issue("rnd", $urandom_range(0, 1), sz, $urandom_range(0, 1), a, $urandom(), 1);
        end
        drain();

        // Reset on a WAIT edge before the commit edge.
        issue("ab1_sw", 1, SZ_WORD, 0, 32'h40, 32'hDEAD_BEEF, 0);
        do_reset();
        issue("ab1_lw", 0, SZ_WORD, 0, 32'h40, 32'h0, 1);
        drain();

        // Reset landing exactly on the commit edge.
        issue("ab2_sw", 1, SZ_WORD, 0, 32'h40, 32'hDEAD_BEEF, 0);
        @(negedge clk);
        do_reset();
        issue("ab2_lw", 0, SZ_WORD, 0, 32'h40, 32'h0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
